amp_envelope: RTL



---
 rtl/amp_pkg.sv | 27 ++
 rtl/env_tracker.sv | 88 ++++++++
 rtl/amp_envelope.sv | 76 +++++++
 3 files changed

// File: rtl/amp_pkg.sv
// Shared definitions for the amplitude producer/consumer pair (amp_envelope, amp_limiter).
// Holds the word width, default tuning values and the sample magnitude helper.
package amp_pkg;

    localparam int AMP_W = 16;

    localparam int DEF_DECIM        = 4;
    localparam int DEF_ATTACK_SHIFT = 0;
    localparam int DEF_HOLD_SAMPLES = 8;
    localparam int DEF_DECAY_SHIFT  = 4;
    localparam int DEF_CLIP_LEVEL   = 32000;

    typedef enum logic [1:0] {
        ENV_ATTACK,
        ENV_HOLD,
        ENV_DECAY
    } env_mode_e;

    // Magnitude of a two's-complement sample as an unsigned word. The result is
    // at most 2**(AMP_W-1), which always fits, so -32768 maps to 32768 unchanged.
    function automatic logic [AMP_W-1:0] abs_sat(input logic signed [AMP_W-1:0] x);
        logic [AMP_W:0] wide;
        wide = x[AMP_W-1] ? ((AMP_W+1)'(0) - {x[AMP_W-1], x}) : {1'b0, x};
        return wide[AMP_W-1:0];
    endfunction

endpackage

// File: rtl/env_tracker.sv
// Peak envelope follower: attack toward larger magnitudes, hold for a number of
// samples after the last peak, then decay geometrically (never below the input).
module env_tracker
    import amp_pkg::*;
#(
    parameter int ATTACK_SHIFT = DEF_ATTACK_SHIFT,
    parameter int HOLD_SAMPLES = DEF_HOLD_SAMPLES,
    parameter int DECAY_SHIFT  = DEF_DECAY_SHIFT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [AMP_W-1:0] mag,
    output logic [AMP_W-1:0] env
);

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_SAMPLES);

    logic [15:0]    hold_cnt;
    logic [15:0]    hold_next;
    logic [AMP_W:0] env_next;
    logic [AMP_W:0] mag_w;
    logic [AMP_W:0] env_w;
    logic [AMP_W:0] attack_step;
    logic [AMP_W:0] decay_step;
    logic [AMP_W:0] decay_cand;
    env_mode_e      mode;

    assign mag_w = {1'b0, mag};
    assign env_w = {1'b0, env};

    // abs == env is not a new peak, so it falls through to hold/decay.
    always_comb begin
        if (mag_w > env_w)
            mode = ENV_ATTACK;
        else if (hold_cnt != '0)
            mode = ENV_HOLD;
        else
            mode = ENV_DECAY;
    end

    // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
    always_comb begin
        attack_step = (mag_w - env_w) >> ATTACK_SHIFT;
        if (attack_step == '0)
            attack_step = (AMP_W+1)'(1);

        decay_step = env_w >> DECAY_SHIFT;
        if (decay_step == '0)
            decay_step = (AMP_W+1)'(1);
        decay_cand = env_w - decay_step;

        env_next  = env_w;
        hold_next = hold_cnt;
        unique case (mode)
            ENV_ATTACK: begin
                env_next  = env_w + attack_step;
                hold_next = HOLD_LOAD;
            end
            ENV_HOLD: begin
                hold_next = hold_cnt - 16'd1;
            end
            ENV_DECAY: begin
                // Floor at the current magnitude; also catches env=0 wrapping below zero.
                if (decay_step > env_w || decay_cand < mag_w)
                    env_next = mag_w;
                else
                    env_next = decay_cand;
            end
            default: begin
                env_next  = env_w;
                hold_next = hold_cnt;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            env      <= '0;
            hold_cnt <= '0;
        end else if (en) begin
            env      <= env_next[AMP_W-1:0];
            hold_cnt <= hold_next;
        end
    end

endmodule

// File: rtl/amp_envelope.sv
// Sample magnitude, clip detection and envelope decimation feeding amp_limiter:
// one amplitude word with a single-cycle valid strobe per DECIM accepted samples.
module amp_envelope
    import amp_pkg::*;
#(
    parameter int DECIM        = DEF_DECIM,
    parameter int ATTACK_SHIFT = DEF_ATTACK_SHIFT,
    parameter int HOLD_SAMPLES = DEF_HOLD_SAMPLES,
    parameter int DECAY_SHIFT  = DEF_DECAY_SHIFT,
    parameter int CLIP_LEVEL   = DEF_CLIP_LEVEL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [AMP_W-1:0] sample,
    output logic [AMP_W-1:0] amplitude,
    output logic             valid,
    output logic             clip
);

    localparam int                 DEC_W    = (DECIM > 2) ? $clog2(DECIM) : 1;
    localparam logic [DEC_W-1:0]   DEC_LAST = DEC_W'(DECIM - 1);
    localparam logic [AMP_W:0]     CLIP_W   = (AMP_W+1)'(CLIP_LEVEL);

    logic [AMP_W-1:0] mag;
    logic [AMP_W-1:0] env;
    logic [DEC_W-1:0] dec_cnt;
    logic             pending;
    logic             block_end;

    assign mag       = abs_sat($signed(sample));
    assign block_end = sample_valid && (dec_cnt == DEC_LAST);

    env_tracker #(
        .ATTACK_SHIFT (ATTACK_SHIFT),
        .HOLD_SAMPLES (HOLD_SAMPLES),
        .DECAY_SHIFT  (DECAY_SHIFT)
    ) u_env_tracker (
        .clk (clk),
        .rst (rst),
        .en  (sample_valid),
        .mag (mag),
        .env (env)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt <= '0;
        end else if (sample_valid) begin
            dec_cnt <= block_end ? '0 : dec_cnt + DEC_W'(1);
        end
    end

    // The strobe lands one edge after the block's last sample, so amplitude
    // captures env including that sample even if a new sample updates env now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= 1'b0;
            valid     <= 1'b0;
            amplitude <= '0;
        end else begin
            pending <= block_end;
            valid   <= pending;
            if (pending)
                amplitude <= env;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            clip <= 1'b0;
        else
            clip <= sample_valid && ({1'b0, mag} >= CLIP_W);
    end

endmodule
